joy2quad_multi: RTL and testbench
=================================

JOY2QUAD_MULTI -- requirements
Module: joy2quad_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent steering channels.
REQ-002 SHALL have parameter DIV_W, default 8: width of clkdiv and the prescaler counter.
REQ-003 SHALL have parameter ACCEL_CYCLES, default 4 (range 1..15): number of completed quadrature cycles of continuous hold before fast mode.
REQ-004 SHALL have port CLK  input  1  sole clock; all state changes on posedge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clkdiv  input  DIV_W  prescaler reload; tick period = clkdiv+1 CLK cycles.
REQ-007 SHALL have port accel_en  input  1  enables fast mode for all channels.
REQ-008 SHALL have port left  input  CHANNELS  per-channel left button, active-high.
REQ-009 SHALL have port right  input  CHANNELS  per-channel right button, active-high.
REQ-010 SHALL have port steer  output  2*CHANNELS  registered quadrature pair; channel i occupies bits [2i+1:2i].
REQ-011 SHALL have port moving  output  CHANNELS  registered; 1 while channel i is mid-cycle (state not IDLE).

Function
REQ-012 SHALL have one shared prescaler: if cnt==0, assert tick for that cycle and load cnt<=clkdiv; otherwise cnt<=cnt-1. With clkdiv=0, tick is asserted every cycle.
REQ-013 SHALL have per channel: state in {IDLE, L1, L2, L3, R1, R2, R3}, a 1-bit sub toggle, and a 4-bit hold counter.
REQ-014 SHALL define fast = accel_en && hold==ACCEL_CYCLES.
REQ-015 SHALL generate a step for a channel only on tick.
- Fast: every tick is a step.
- Slow: sub toggles on each tick, and a step occurs on ticks where sub was 1.
REQ-016 SHALL, on a step in IDLE, sample the inputs exactly once.
- left only: state L1, steer 01.
- right only: state R1, steer 10.
- Neither or both: stay IDLE, steer 00, hold<=0.
REQ-017 SHALL step L1->L2->L3->IDLE with steer 11, 10, 00.
REQ-018 SHALL step R1->R2->R3->IDLE with steer 11, 01, 00.
REQ-019 SHALL, once a cycle has started, complete it to steer 00 regardless of input changes (release, reversal, or both pressed mid-cycle).
REQ-020 SHALL, on the step entering IDLE from L3/R3, set hold<=min(hold+1, ACCEL_CYCLES) if the same single direction is still held; otherwise hold<=0.
REQ-021 SHALL clear hold to 0 whenever sampled input in IDLE differs from the direction of the last completed cycle, so a reversal restarts in slow mode.
REQ-022 SHALL clear sub to 0 whenever a channel is in IDLE and the sampled input is neither or both.
REQ-023 SHALL keep channels fully independent apart from the shared tick; simultaneous steps on all channels are legal.
REQ-024 SHALL change at most one bit of steer per channel per step (Gray sequence).
REQ-025 SHALL update steer and moving only on steps; outputs stay stable between steps.
REQ-026 SHALL have a latency of one CLK from a stepping tick edge to the new steer value (registered).
REQ-027 SHALL sample clkdiv only at reload; a change takes effect after the current count expires.

Reset
REQ-028 SHALL, on RESET=1, immediately and without CLK set cnt=0, every state=IDLE, sub=0, hold=0, steer=0, moving=0.
REQ-029 SHALL, if RESET asserts mid-cycle, abandon the cycle; steer=00 with no completion of the sequence.
REQ-030 SHALL, after RESET deasserts, produce the first tick on the first CLK edge (cnt==0).

Verification
REQ-031 SHALL be verified with: clkdiv=3, accel_en=0, left[0] held -> steer[1:0] = 01,11,10,00 repeating; one change every 8 CLK; moving[0]=1 except in IDLE.
REQ-032 SHALL be verified with: clkdiv=3, right[1] pulsed for 1 step, then released -> steer[3:2] = 10,11,01,00 completes, then stays 00.
REQ-033 SHALL be verified with: accel_en=1, ACCEL_CYCLES=4, left[0] held -> first 4 cycles at 8 CLK/step, then 4 CLK/step; releasing, then re-pressing returns to 8 CLK/step.
REQ-034 SHALL be verified with: left and right both high in IDLE -> steer stays 00, moving 0; both going high mid L2 -> cycle finishes 10,00, then idles.
REQ-035 SHALL be verified with: RESET pulsed asynchronously while steer[1:0]=11 -> steer=00, moving=0 before the next CLK edge; the sequence restarts from L1.
REQ-036 SHALL be verified with: clkdiv=0, fast mode on channel 0, right[1] slow -> channel 0 steps every CLK, channel 1 every 2 CLK; no cross-channel interference.

Source files
------------

// File: rtl/joy2quad_multi.sv
// joy2quad_multi: left/right buttons to quadrature steering, per channel.
// Ports: CLK, RESET (async high), clkdiv, accel_en, left, right,
//        steer[2i+1:2i] (quadrature pair), moving[i] (mid-cycle).
module joy2quad_multi #(
    parameter int CHANNELS     = 2,
    parameter int DIV_W        = 8,
    parameter int ACCEL_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DIV_W-1:0]      clkdiv,
    input  logic                  accel_en,
    input  logic [CHANNELS-1:0]   left,
    input  logic [CHANNELS-1:0]   right,
    output logic [2*CHANNELS-1:0] steer,
    output logic [CHANNELS-1:0]   moving
);

    typedef enum logic [2:0] {
        IDLE,
        L1,
        L2,
        L3,
        R1,
        R2,
        R3
    } state_t;

    localparam logic [3:0] ACC = 4'(ACCEL_CYCLES);

    logic [DIV_W-1:0] cnt;
    logic             tick;

    // Shared prescaler; clkdiv is only looked at on reload.
    assign tick = (cnt == '0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= clkdiv;
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t     state_q, state_d;
        logic       sub_q, sub_d;
        logic [3:0] hold_q, hold_d;
        logic       dir_q, dir_d;
        logic [1:0] steer_q, steer_d;
        logic       moving_q, moving_d;
        logic       go_l, go_r;
        logic       fast, step;
        logic [3:0] hold_inc;

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                state_q  <= IDLE;
                sub_q    <= 1'b0;
                hold_q   <= '0;
                dir_q    <= 1'b0;
                steer_q  <= 2'b00;
                moving_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                sub_q    <= sub_d;
                hold_q   <= hold_d;
                dir_q    <= dir_d;
                steer_q  <= steer_d;
                moving_q <= moving_d;
            end
        end

        always_comb begin
            go_l     = left[i] & ~right[i];
            go_r     = right[i] & ~left[i];
            fast     = accel_en && (hold_q == ACC);
            step     = tick && (fast || sub_q);
            hold_inc = (hold_q >= ACC) ? ACC : hold_q + 4'd1;

            state_d  = state_q;
            sub_d    = sub_q;
            hold_d   = hold_q;
            dir_d    = dir_q;
            steer_d  = steer_q;
            moving_d = moving_q;

            // sub only paces slow mode; an idle channel with no
            // single direction keeps it cleared so a press starts
            // from a known phase.
            if (tick && !fast) begin
                sub_d = ~sub_q;
            end
            if (tick && state_q == IDLE && !go_l && !go_r) begin
                sub_d = 1'b0;
            end

            if (step) begin
                unique case (state_q)
                    IDLE: begin
                        if (go_l) begin
                            state_d = L1;
                            steer_d = 2'b01;
                            dir_d   = 1'b0;
                            if (dir_q) begin
                                hold_d = '0;
                            end
                        end else if (go_r) begin
                            state_d = R1;
                            steer_d = 2'b10;
                            dir_d   = 1'b1;
                            if (!dir_q) begin
                                hold_d = '0;
                            end
                        end else begin
                            steer_d = 2'b00;
                            hold_d  = '0;
                        end
                    end
                    L1: begin
                        state_d = L2;
                        steer_d = 2'b11;
                    end
                    L2: begin
                        state_d = L3;
                        steer_d = 2'b10;
                    end
                    L3: begin
                        state_d = IDLE;
                        steer_d = 2'b00;
                        hold_d  = go_l ? hold_inc : 4'd0;
                    end
                    R1: begin
                        state_d = R2;
                        steer_d = 2'b11;
                    end
                    R2: begin
                        state_d = R3;
                        steer_d = 2'b01;
                    end
                    R3: begin
                        state_d = IDLE;
                        steer_d = 2'b00;
                        hold_d  = go_r ? hold_inc : 4'd0;
                    end
                    default: begin
                        state_d = IDLE;
                        steer_d = 2'b00;
                    end
                endcase
                moving_d = (state_d != IDLE);
            end
        end

        assign steer[2*i +: 2] = steer_q;
        assign moving[i]       = moving_q;
    end

endmodule

// File: tb/tb_joy2quad_multi.sv
// tb_joy2quad_multi: directed vector bench for joy2quad_multi.
// Table rows plus hand sequences for acceleration and async reset.
module tb_joy2quad_multi;

    logic       CLK;
    logic       RESET;
    logic [7:0] clkdiv;
    logic       accel_en;
    logic [1:0] left;
    logic [1:0] right;
    logic [3:0] steer;
    logic [1:0] moving;

    int n_cmp = 0;
    int n_bad = 0;

    joy2quad_multi #(
        .CHANNELS(2),
        .DIV_W(8),
        .ACCEL_CYCLES(4)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .clkdiv(clkdiv),
        .accel_en(accel_en),
        .left(left),
        .right(right),
        .steer(steer),
        .moving(moving)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] l;
        logic [1:0] r;
        logic       acc;
        logic [7:0] div;
        int         n;
        logic [3:0] st;
        logic [1:0] mv;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_d[$];

    function automatic vec_t mk(logic [1:0] l, logic [1:0] r,
                                logic acc, logic [7:0] div, int n,
                                logic [3:0] st, logic [1:0] mv);
        vec_t v;
        v.l = l; v.r = r; v.acc = acc; v.div = div;
        v.n = n; v.st = st; v.mv = mv;
        return v;
    endfunction

    task automatic chk(string nm, logic [3:0] st_e, logic [1:0] mv_e);
        n_cmp++;
        if (steer !== st_e || moving !== mv_e) begin
            n_bad++;
            $display("FAIL %s: steer=%b moving=%b, required steer=%b moving=%b",
                     nm, steer, moving, st_e, mv_e);
        end
    endtask

    task automatic do_reset(logic [7:0] div, logic acc, string nm);
        @(negedge CLK);
        RESET    = 1'b1;
        clkdiv   = div;
        accel_en = acc;
        left     = 2'b00;
        right    = 2'b00;
        #1;
        chk(nm, 4'b0000, 2'b00);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic run_row(vec_t v, string nm);
        left     = v.l;
        right    = v.r;
        accel_en = v.acc;
        clkdiv   = v.div;
        repeat (v.n) @(posedge CLK);
        #1;
        chk(nm, v.st, v.mv);
    endtask

    task automatic after(int n, logic [3:0] st, logic [1:0] mv, string nm);
        repeat (n) @(posedge CLK);
        #1;
        chk(nm, st, mv);
    endtask

    initial begin
        RESET    = 1'b1;
        clkdiv   = 8'd3;
        accel_en = 1'b0;
        left     = 2'b00;
        right    = 2'b00;

        // clkdiv=3, slow: ticks every 4 CLK, steps every 8 CLK.
        tab_a.push_back(mk(2'b01, 2'b00, 0, 3,  4, 4'b0000, 2'b00));
        tab_a.push_back(mk(2'b01, 2'b00, 0, 3,  1, 4'b0001, 2'b01));
        tab_a.push_back(mk(2'b01, 2'b00, 0, 3,  7, 4'b0001, 2'b01));
        tab_a.push_back(mk(2'b01, 2'b00, 0, 3,  1, 4'b0011, 2'b01));
        tab_a.push_back(mk(2'b01, 2'b00, 0, 3,  8, 4'b0010, 2'b01));
        tab_a.push_back(mk(2'b01, 2'b00, 0, 3,  8, 4'b0000, 2'b00));
        tab_a.push_back(mk(2'b01, 2'b00, 0, 3,  8, 4'b0001, 2'b01));
        tab_a.push_back(mk(2'b00, 2'b00, 0, 3,  8, 4'b0011, 2'b01));
        tab_a.push_back(mk(2'b00, 2'b00, 0, 3,  8, 4'b0010, 2'b01));
        tab_a.push_back(mk(2'b00, 2'b00, 0, 3,  8, 4'b0000, 2'b00));
        tab_a.push_back(mk(2'b00, 2'b00, 0, 3, 16, 4'b0000, 2'b00));
        tab_a.push_back(mk(2'b00, 2'b10, 0, 3,  8, 4'b1000, 2'b10));
        tab_a.push_back(mk(2'b00, 2'b00, 0, 3,  8, 4'b1100, 2'b10));
        tab_a.push_back(mk(2'b00, 2'b00, 0, 3,  8, 4'b0100, 2'b10));
        tab_a.push_back(mk(2'b00, 2'b00, 0, 3,  8, 4'b0000, 2'b00));
        tab_a.push_back(mk(2'b00, 2'b00, 0, 3, 16, 4'b0000, 2'b00));
        tab_a.push_back(mk(2'b01, 2'b01, 0, 3, 16, 4'b0000, 2'b00));
        tab_a.push_back(mk(2'b01, 2'b00, 0, 3, 16, 4'b0011, 2'b01));
        tab_a.push_back(mk(2'b01, 2'b01, 0, 3,  8, 4'b0010, 2'b01));
        tab_a.push_back(mk(2'b01, 2'b01, 0, 3,  8, 4'b0000, 2'b00));
        tab_a.push_back(mk(2'b00, 2'b00, 0, 3, 16, 4'b0000, 2'b00));

        // clkdiv=0: ch0 reaches fast mode, ch1 runs slow alongside.
        tab_d.push_back(mk(2'b01, 2'b00, 1, 0, 31, 4'b0010, 2'b01));
        tab_d.push_back(mk(2'b01, 2'b00, 1, 0,  1, 4'b0000, 2'b00));
        tab_d.push_back(mk(2'b01, 2'b10, 1, 0,  1, 4'b0001, 2'b01));
        tab_d.push_back(mk(2'b01, 2'b10, 1, 0,  1, 4'b1011, 2'b11));
        tab_d.push_back(mk(2'b01, 2'b10, 1, 0,  1, 4'b1010, 2'b11));
        tab_d.push_back(mk(2'b01, 2'b10, 1, 0,  1, 4'b1100, 2'b10));
        tab_d.push_back(mk(2'b01, 2'b10, 1, 0,  1, 4'b1101, 2'b11));
        tab_d.push_back(mk(2'b01, 2'b10, 1, 0,  1, 4'b0111, 2'b11));
        tab_d.push_back(mk(2'b01, 2'b10, 1, 0,  1, 4'b0110, 2'b11));
        tab_d.push_back(mk(2'b01, 2'b10, 1, 0,  1, 4'b0000, 2'b00));
        tab_d.push_back(mk(2'b01, 2'b10, 1, 0,  1, 4'b0001, 2'b01));
        tab_d.push_back(mk(2'b01, 2'b10, 1, 0,  1, 4'b1011, 2'b11));

        do_reset(8'd3, 1'b0, "reset_a");
        for (int k = 0; k < tab_a.size(); k++) begin
            run_row(tab_a[k], $sformatf("tab_a[%0d]", k));
        end

        // Acceleration: 4 slow cycles, then 4 CLK per step.
        do_reset(8'd3, 1'b1, "reset_b");
        left = 2'b01;
        after(124, 4'b0010, 2'b01, "acc_c4_l3");
        after(1,   4'b0000, 2'b00, "acc_c4_end");
        after(3,   4'b0000, 2'b00, "acc_gap");
        after(1,   4'b0001, 2'b01, "acc_fast_l1");
        after(3,   4'b0001, 2'b01, "acc_fast_hold");
        after(1,   4'b0011, 2'b01, "acc_fast_l2");
        after(4,   4'b0010, 2'b01, "acc_fast_l3");
        after(4,   4'b0000, 2'b00, "acc_fast_idle");
        after(4,   4'b0001, 2'b01, "acc_fast_l1b");
        left = 2'b00;
        after(4,   4'b0011, 2'b01, "rel_l2");
        after(4,   4'b0010, 2'b01, "rel_l3");
        after(4,   4'b0000, 2'b00, "rel_idle");
        after(4,   4'b0000, 2'b00, "rel_stay");
        left = 2'b01;
        after(8,   4'b0001, 2'b01, "repress_l1");
        after(7,   4'b0001, 2'b01, "repress_slow");
        after(1,   4'b0011, 2'b01, "repress_l2");

        // Asynchronous reset mid-cycle, no clock edge involved.
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst", 4'b0000, 2'b00);
        #1;
        RESET = 1'b0;
        after(4, 4'b0000, 2'b00, "post_rst_wait");
        after(1, 4'b0001, 2'b01, "post_rst_l1");
        after(8, 4'b0011, 2'b01, "post_rst_l2");

        do_reset(8'd0, 1'b1, "reset_d");
        for (int k = 0; k < tab_d.size(); k++) begin
            run_row(tab_d[k], $sformatf("tab_d[%0d]", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
